// File: rtl/stb_gen_ctrl_pkg.sv
// Shared types and default parameters for the strobe generator sequencer.
package stb_gen_ctrl_pkg;

  localparam int DEF_T_CNT_WIDTH = 32;
  localparam int DEF_DET_CYCLES  = 42;
  localparam int DEF_TO_WIDTH    = 24;
  localparam int DEF_NSTB_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DET      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_STB      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    STAT_OK      = 3'd0,
    STAT_TIMEOUT = 3'd1,
    STAT_ERR     = 3'd2,
    STAT_ABORT   = 3'd3,
    STAT_ZERO    = 3'd4
  } status_t;

endpackage

// File: rtl/stb_gen_ctrl_if.sv
// Handshake between the sequencer (master) and stb_gen (slave).
interface stb_gen_ctrl_if #(
  parameter int T_CNT_WIDTH = 32
);
  logic                   run_det_o;
  logic                   stb_req_o;
  logic                   oe_o;
  logic                   rdy_i;
  logic                   err_i;
  logic                   stb_valid_i;
  logic [T_CNT_WIDTH-1:0] stb_period_i;

  modport master (
    output run_det_o, stb_req_o, oe_o,
    input  rdy_i, err_i, stb_valid_i, stb_period_i
  );

  modport slave (
    input  run_det_o, stb_req_o, oe_o,
    output rdy_i, err_i, stb_valid_i, stb_period_i
  );
endinterface

// File: rtl/stb_gen_ctrl_timer.sv
// Phase timer: counts cycles spent in a timed state. Loading 1 on entry makes
// the count equal to the number of cycles spent so far, so match means
// "this is the limit-th cycle".
module stb_gen_ctrl_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             match_o
);

  logic [WIDTH-1:0] cnt_q;

  // counter register: clear beats load beats increment
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)      cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (ld_i)   cnt_q <= ld_val_i;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign match_o = (cnt_q == limit_i);

endmodule

// File: rtl/stb_gen_ctrl.sv
// Strobe generator sequencer: detection, lock wait with timeout, strobe burst.
//
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_DET      | run_det pulse, DET_CYCLES long
//   ST_WAIT_RDY | waiting for period lock, optional timeout
//   ST_STB      | issuing strobe requests, counting valid strobes
//   ST_DONE     | one-cycle completion pulse
module stb_gen_ctrl
  import stb_gen_ctrl_pkg::*;
#(
  parameter int T_CNT_WIDTH = DEF_T_CNT_WIDTH,
  parameter int DET_CYCLES  = DEF_DET_CYCLES,
  parameter int TO_WIDTH    = DEF_TO_WIDTH,
  parameter int NSTB_WIDTH  = DEF_NSTB_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NSTB_WIDTH-1:0]  n_stb_i,
  input  logic [TO_WIDTH-1:0]    timeout_i,
  stb_gen_ctrl_if.master         gen,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2:0]             status_o,
  output logic [T_CNT_WIDTH-1:0] period_o,
  output logic [NSTB_WIDTH-1:0]  stb_cnt_o
);

  state_t                state_q, state_nxt;
  status_t               status_q, status_nxt;
  logic                  start_acc, period_ld, cnt_hit, stb_inc;
  logic [NSTB_WIDTH-1:0] n_stb_q;
  logic [TO_WIDTH-1:0]   timeout_q, tmr_limit;
  logic                  timed_nxt, tmr_clr, tmr_ld, tmr_en, tmr_match;

  stb_gen_ctrl_timer #(.WIDTH(TO_WIDTH)) u_timer (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .clr_i    (tmr_clr),
    .ld_i     (tmr_ld),
    .ld_val_i (TO_WIDTH'(1)),
    .en_i     (tmr_en),
    .limit_i  (tmr_limit),
    .match_o  (tmr_match)
  );

  // next-state and status decode; abort > err > rdy/count > timeout
  always_comb begin
    state_nxt  = state_q;
    status_nxt = status_q;
    period_ld  = 1'b0;
    start_acc  = (state_q == ST_IDLE) && start_i;
    cnt_hit    = (n_stb_q != '0) && (stb_cnt_o == n_stb_q);
    stb_inc    = (state_q == ST_STB) && gen.stb_valid_i && !cnt_hit;
    tmr_limit  = (state_q == ST_DET) ? TO_WIDTH'(DET_CYCLES) : timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt  = ST_DET;
          status_nxt = STAT_OK;
        end
      end
      ST_DET: begin
        if (abort_i) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_ABORT;
        end else if (tmr_match) begin
          state_nxt = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (abort_i) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_ABORT;
        end else if (gen.err_i) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_ERR;
        end else if (gen.rdy_i) begin
          period_ld = 1'b1;
          if (gen.stb_period_i == '0) begin
            state_nxt  = ST_DONE;
            status_nxt = STAT_ZERO;
          end else begin
            state_nxt = ST_STB;
          end
        end else if ((timeout_q != '0) && tmr_match) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_TIMEOUT;
        end
      end
      ST_STB: begin
        if (abort_i) begin
          state_nxt  = ST_DONE;
          status_nxt = (n_stb_q == '0) ? STAT_OK : STAT_ABORT;
        end else if (gen.err_i) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_ERR;
        end else if (cnt_hit) begin
          state_nxt  = ST_DONE;
          status_nxt = STAT_OK;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // timer restarts at 1 on entry to a timed state and is held clear elsewhere
  always_comb begin
    timed_nxt = (state_nxt == ST_DET) || (state_nxt == ST_WAIT_RDY);
    tmr_clr   = !timed_nxt;
    tmr_ld    = timed_nxt && (state_nxt != state_q);
    tmr_en    = timed_nxt && (state_nxt == state_q);
  end

  // state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // registered control outputs, decoded from the state being entered
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      gen.run_det_o <= 1'b0;
      gen.stb_req_o <= 1'b0;
      gen.oe_o      <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      gen.run_det_o <= (state_nxt == ST_DET);
      gen.stb_req_o <= (state_nxt == ST_STB);
      gen.oe_o      <= (state_nxt == ST_STB);
      busy_o        <= (state_nxt != ST_IDLE);
      done_o        <= (state_nxt == ST_DONE);
    end
  end

  // run parameters, result registers and the saturating strobe counter
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      n_stb_q   <= '0;
      timeout_q <= '0;
      period_o  <= '0;
      stb_cnt_o <= '0;
      status_q  <= STAT_OK;
    end else begin
      status_q <= status_nxt;
      if (start_acc) begin
        n_stb_q   <= n_stb_i;
        timeout_q <= timeout_i;
        period_o  <= '0;
        stb_cnt_o <= '0;
      end else begin
        if (period_ld) period_o <= gen.stb_period_i;
        if (stb_inc && (stb_cnt_o != '1)) stb_cnt_o <= stb_cnt_o + 1'b1;
      end
    end
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_stb_gen_ctrl.sv
// Directed bench for stb_gen_ctrl with hand-computed expectations.
module tb_stb_gen_ctrl;
  import stb_gen_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] n_stb_i = '0;
  logic [23:0] timeout_i = '0;
  logic        busy_o, done_o;
  logic [2:0]  status_o;
  logic [31:0] period_o;
  logic [15:0] stb_cnt_o;
  int          n_chk = 0;
  int          n_err = 0;
  logic        req_seen = 1'b0;
  int          n;

  stb_gen_ctrl_if #(.T_CNT_WIDTH(32)) gen_if ();

  stb_gen_ctrl #(
    .T_CNT_WIDTH(32), .DET_CYCLES(42), .TO_WIDTH(24), .NSTB_WIDTH(16)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .n_stb_i   (n_stb_i),
    .timeout_i (timeout_i),
    .gen       (gen_if.master),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .status_o  (status_o),
    .period_o  (period_o),
    .stb_cnt_o (stb_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (gen_if.stb_req_o) req_seen = 1'b1;
  endtask

  task automatic do_start(input logic [15:0] ns, input logic [23:0] to);
    n_stb_i   = ns;
    timeout_i = to;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_det(output int cnt);
    cnt = 0;
    while (gen_if.run_det_o && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (!done_o && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic give_rdy(input logic [31:0] per);
    gen_if.rdy_i        = 1'b1;
    gen_if.stb_period_i = per;
    tick();
    gen_if.rdy_i        = 1'b0;
  endtask

  task automatic strobe();
    gen_if.stb_valid_i = 1'b1;
    tick();
    gen_if.stb_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    gen_if.rdy_i        = 1'b0;
    gen_if.err_i        = 1'b0;
    gen_if.stb_valid_i  = 1'b0;
    gen_if.stb_period_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_run_det", 32'(gen_if.run_det_o), 0);
    arst_i = 1'b0;
    tick();

    // nominal run
    do_start(16'd5, 24'd1000);
    chk("nom_busy_rise", 32'(busy_o), 1);
    wait_det(n);
    chk("nom_det_len", n, 42);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_start_ignored", 32'(gen_if.run_det_o), 0);
    repeat (18) tick();
    give_rdy(32'd250);
    chk("nom_period", period_o, 250);
    chk("nom_stb_req_rise", 32'(gen_if.stb_req_o), 1);
    chk("nom_oe_rise", 32'(gen_if.oe_o), 1);
    repeat (4) strobe();
    gen_if.stb_valid_i = 1'b1;
    tick();
    gen_if.stb_valid_i = 1'b0;
    chk("nom_cnt", 32'(stb_cnt_o), 5);
    chk("nom_req_hold", 32'(gen_if.stb_req_o), 1);
    tick();
    chk("nom_done", 32'(done_o), 1);
    chk("nom_req_fall", 32'(gen_if.stb_req_o), 0);
    chk("nom_status", 32'(status_o), 0);
    chk("nom_busy_in_done", 32'(busy_o), 1);
    tick();
    chk("nom_done_one_cycle", 32'(done_o), 0);
    chk("nom_busy_fall", 32'(busy_o), 0);

    // timeout
    req_seen = 1'b0;
    do_start(16'd3, 24'd100);
    wait_det(n);
    wait_done(300, n);
    chk("to_cycles", n, 100);
    chk("to_status", 32'(status_o), 1);
    chk("to_no_req", 32'(req_seen), 0);
    tick();

    // err together with rdy
    do_start(16'd5, 24'd1000);
    wait_det(n);
    repeat (3) tick();
    gen_if.err_i = 1'b1;
    give_rdy(32'd77);
    gen_if.err_i = 1'b0;
    chk("errrdy_done", 32'(done_o), 1);
    chk("errrdy_status", 32'(status_o), 2);
    chk("errrdy_period", period_o, 0);
    tick();

    // err after two strobes
    do_start(16'd5, 24'd1000);
    wait_det(n);
    give_rdy(32'd9);
    strobe();
    strobe();
    gen_if.err_i = 1'b1;
    tick();
    gen_if.err_i = 1'b0;
    chk("errstb_done", 32'(done_o), 1);
    chk("errstb_status", 32'(status_o), 2);
    chk("errstb_cnt", 32'(stb_cnt_o), 2);
    chk("errstb_period", period_o, 9);
    tick();

    // free-run with no timeout, then abort
    do_start(16'd0, 24'd0);
    wait_det(n);
    repeat (60) tick();
    chk("fr_no_timeout", 32'(busy_o), 1);
    give_rdy(32'd33);
    gen_if.stb_valid_i = 1'b1;
    repeat (300) tick();
    gen_if.stb_valid_i = 1'b0;
    repeat (3) tick();
    chk("fr_cnt_running", 32'(stb_cnt_o), 300);
    chk("fr_req_high", 32'(gen_if.stb_req_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("fr_done", 32'(done_o), 1);
    chk("fr_status", 32'(status_o), 0);
    chk("fr_cnt", 32'(stb_cnt_o), 300);
    tick();

    // abort during DET
    do_start(16'd5, 24'd1000);
    repeat (10) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abdet_run_det", 32'(gen_if.run_det_o), 0);
    chk("abdet_done", 32'(done_o), 1);
    chk("abdet_status", 32'(status_o), 3);
    tick();

    // zero period, start during the done cycle
    do_start(16'd5, 24'd1000);
    wait_det(n);
    give_rdy(32'd0);
    chk("zero_done", 32'(done_o), 1);
    chk("zero_status", 32'(status_o), 4);
    chk("zero_no_req", 32'(gen_if.stb_req_o), 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("done_start_busy", 32'(busy_o), 0);
    tick();
    chk("done_start_run_det", 32'(gen_if.run_det_o), 0);
    chk("zero_status_hold", 32'(status_o), 4);

    // asynchronous reset in STB, then a fresh run
    do_start(16'd5, 24'd1000);
    wait_det(n);
    give_rdy(32'd123);
    strobe();
    #2 arst_i = 1'b1;
    #1;
    chk("rst_req", 32'(gen_if.stb_req_o), 0);
    chk("rst_oe", 32'(gen_if.oe_o), 0);
    chk("rst_busy_mid", 32'(busy_o), 0);
    chk("rst_period", period_o, 0);
    chk("rst_cnt", 32'(stb_cnt_o), 0);
    @(posedge clk_i);
    #1 arst_i = 1'b0;
    tick();
    chk("rst_idle", 32'(busy_o), 0);
    do_start(16'd1, 24'd1000);
    wait_det(n);
    chk("re_det_len", n, 42);
    give_rdy(32'd5);
    gen_if.stb_valid_i = 1'b1;
    tick();
    gen_if.stb_valid_i = 1'b0;
    tick();
    chk("re_done", 32'(done_o), 1);
    chk("re_status", 32'(status_o), 0);
    chk("re_cnt", 32'(stb_cnt_o), 1);
    chk("re_period", period_o, 5);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stb_gen_ctrl.md
# stb_gen_ctrl

Sequencer for the strobe generator in the measure unit. On a software start it runs the detection phase, waits for period lock with a timeout, latches the measured period and issues a programmed number of strobe requests. It reports a completion pulse and a status code. It sits between the CSR block and `stb_gen`, and owns the `run_det`, `stb_req` and `oe` controls.

## Interface
- `T_CNT_WIDTH`, 32, width of the period count from `stb_gen`
- `DET_CYCLES`, 42, length of the `run_det_o` pulse in clk cycles (≥1)
- `TO_WIDTH`, 24, timeout counter width
- `NSTB_WIDTH`, 16, strobe count width
- `clk_i`  in  1  system clock
- `arst_i`  in  1  asynchronous, active-high reset
- `start_i`  in  1  one-cycle start request from CSR
- `abort_i`  in  1  level; ends any running sequence
- `n_stb_i`  in  NSTB_WIDTH  strobes to issue; 0 = free-run until abort
- `timeout_i`  in  TO_WIDTH  WAIT_RDY limit in cycles; 0 = no timeout
- `rdy_i`, `err_i`, `stb_valid_i`  in  1  from `stb_gen`
- `stb_period_i`  in  T_CNT_WIDTH  measured period from `stb_gen`
- `run_det_o`, `stb_req_o`, `oe_o`  out  1  to `stb_gen`
- `busy_o`  out  1  high in any state except IDLE
- `done_o`  out  1  one-cycle completion pulse
- `status_o`  out  3  result code (see Operation)
- `period_o`  out  T_CNT_WIDTH  period latched at lock
- `stb_cnt_o`  out  NSTB_WIDTH  strobes completed in the current run

## Operation
- FSM states: IDLE, DET, WAIT_RDY, STB, DONE.
- IDLE to DET on `start_i`.
  - On this transition, clear `stb_cnt_o`, `period_o` and `status_o`, and latch `n_stb_i` and `timeout_i`.
  - `start_i` is ignored in every other state.
- DET: `run_det_o`=1. After DET_CYCLES cycles, go to WAIT_RDY.
- WAIT_RDY: the timer counts cycles in this state.
  - If `err_i`=1: status ERR(2), go to DONE.
  - Else if `rdy_i`=1: latch `period_o`=`stb_period_i`.
    - If `stb_period_i`==0: status ZERO(4), go to DONE.
    - Otherwise go to STB.
  - Else if `timeout_i`≠0 and the count reaches `timeout_i`: status TIMEOUT(1), go to DONE.
- STB: `oe_o`=1 and `stb_req_o`=1.
  - Each cycle with `stb_valid_i`=1 increments `stb_cnt_o`; in free-run the count saturates at all-ones.
  - When the count reaches the latched nonzero `n_stb`: status OK(0), go to DONE, and `stb_req_o` drops the next cycle.
  - If `err_i`=1: status ERR, go to DONE.
- `abort_i` in DET, WAIT_RDY or STB: go to DONE.
  - Status is OK if in STB with `n_stb`==0, otherwise ABORT(3).
  - Abort has the highest priority, then err, then rdy/count, then timeout.
- DONE: `done_o`=1 for exactly one cycle, then go to IDLE.
- `status_o`, `period_o` and `stb_cnt_o` hold their values until the next accepted start.

## Timing
- All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE. Reset mid-sequence drops `run_det_o`, `stb_req_o` and `oe_o` asynchronously.
- `start_i` sampled at edge k:
  - `busy_o` and `run_det_o` rise after edge k.
  - `run_det_o` stays high for exactly DET_CYCLES cycles.
- The WAIT_RDY timeout fires on the `timeout_i`-th cycle spent in WAIT_RDY.
- `rdy_i` at edge m: `period_o` is valid and `stb_req_o`/`oe_o` rise after edge m.
- The last `stb_valid_i` at edge n: `stb_req_o`/`oe_o` fall and `done_o` rises after n+1; `busy_o` falls after n+2.
- Simultaneous `err_i` and `rdy_i`: ERR wins and `period_o` is not updated.
- `start_i` in the same cycle as `done_o` is ignored.

## Structure
- `stb_gen_ctrl_pkg` holds:
  - the `state_t` enum
  - the `status_t` enum (OK=0, TIMEOUT=1, ERR=2, ABORT=3, ZERO=4)
  - default parameter constants
- Sub-module `stb_gen_ctrl_timer` is a loadable up-counter with a clear input and a match flag against a TO_WIDTH limit. It is shared by DET (limit DET_CYCLES) and WAIT_RDY (limit `timeout_i`).
- Everything else (FSM and strobe counter) lives in `stb_gen_ctrl`.

## Test plan
- Nominal run:
  - Stimulus: start, `n_stb`=5, `timeout`=1000; `rdy_i` 20 cycles after DET with period 250; five `stb_valid_i` pulses.
  - Response: `run_det_o` high 42 cycles, `period_o`=250, `stb_cnt_o`=5, status 0, one `done_o` pulse.
- Timeout:
  - Stimulus: `timeout`=100, `rdy_i` never asserted.
  - Response: `done_o` exactly 100 WAIT_RDY cycles after DET, status 1, `stb_req_o` never high.
- Error handling:
  - Stimulus: `err_i` together with `rdy_i`.
  - Response: status 2, `period_o`=0.
  - Stimulus: `err_i` after 2 strobes.
  - Response: status 2, `stb_cnt_o`=2.
- Free-run and abort:
  - Stimulus: `n_stb`=0, 300 `stb_valid_i` pulses, then `abort_i`.
  - Response: status 0, `stb_cnt_o`=300.
  - Stimulus: abort during DET.
  - Response: status 3, `run_det_o` drops next cycle.
- Zero period and start rejection:
  - Stimulus: `rdy_i` with period 0.
  - Response: status 4.
  - Stimulus: `start_i` pulses while busy or in the `done_o` cycle.
  - Response: no restart.
- Reset mid-STB:
  - Stimulus: assert `arst_i` asynchronously while in STB.
  - Response: all outputs 0 immediately; FSM in IDLE after release; a new start works normally.
